// File: rtl/saph_num_unpack_stream.sv
// saph_num_unpack_stream
// Reader side of saph_num_pack. Packed words are appended to a bit buffer, and
// variable-width fields are taken LSB-first from it. A field may straddle a
// word boundary. Each w-bit field is widened to unpack_width bits by repeating
// it MSB-first, so the top bits of the original value come back exactly.
//
// Handshakes use strict valid/ready semantics. A transfer happens on a rising
// edge where valid && ready are both high. A producer must hold its data stable
// while valid is high and ready is low. in_ready never depends on out_ready.
// out_valid and out_data are combinational from registered state and cfg_width.
module saph_num_unpack_stream #(
    parameter int  pack_width   = 8,
    parameter int  unpack_width = 8,
    localparam int unpack_exp   = $clog2(unpack_width + 1),
    localparam int cnt_exp      = $clog2(2 * pack_width + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [unpack_exp-1:0]   cfg_width,
    input  logic                    flush,
    input  logic [pack_width-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [unpack_width-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [cnt_exp-1:0]      bits_avail
);

    localparam int buf_width = 2 * pack_width;
    localparam logic [unpack_exp-1:0] w_max     = unpack_exp'(unpack_width);
    localparam logic [cnt_exp-1:0]    word_bits = cnt_exp'(pack_width);

    // Bit 0 of bit_buf is the oldest unconsumed bit.
    // Bits at positions >= cnt are always zero, so a new word can be ORed in.
    logic [buf_width-1:0]    bit_buf;
    logic [cnt_exp-1:0]      cnt;

    logic [unpack_exp-1:0]   w;
    logic [cnt_exp-1:0]      w_cnt;
    logic                    accept;
    logic                    consume;
    logic [cnt_exp-1:0]      used;
    logic [cnt_exp-1:0]      shift_in;
    logic [buf_width-1:0]    buf_next;
    logic [cnt_exp-1:0]      cnt_next;
    logic [unpack_width-1:0] field_exp;
    logic [unpack_exp-1:0]   rep_idx;

    // A requested width larger than one output number is treated as a full-width field.
    assign w     = (cfg_width > w_max) ? w_max : cfg_width;
    assign w_cnt = cnt_exp'(w);

    // Room for one more word exists while at most one word's worth of bits is buffered.
    assign in_ready   = !rst && !flush && (cnt <= word_bits);
    assign out_valid  = !rst && (cnt >= w_cnt);
    assign out_data   = rst ? '0 : field_exp;
    assign bits_avail = cnt;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;
    assign used    = consume ? w_cnt : '0;

    // A new word lands directly above the bits that survive this cycle's consume.
    assign shift_in = cnt - used;
    assign buf_next = (bit_buf >> used)
                    | (accept ? ({{pack_width{1'b0}}, in_data} << shift_in) : '0);
    assign cnt_next = cnt - used + (accept ? word_bits : '0);

    // Widen the w-bit field by repeating it MSB-first from the output's top bit.
    // The last copy is cut short, and its low bits are dropped.
    always_comb begin
        field_exp = '0;
        rep_idx   = w - 1'b1;
        for (int k = unpack_width - 1; k >= 0; k--) begin
            if (w != '0) begin
                field_exp[k] = bit_buf[rep_idx];
            end
            if (rep_idx == '0) begin
                rep_idx = w - 1'b1;
            end else begin
                rep_idx = rep_idx - 1'b1;
            end
        end
    end

    // Buffer and count update. Reset and flush both drop every buffered bit.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bit_buf <= '0;
            cnt     <= '0;
        end else begin
            bit_buf <= buf_next;
            cnt     <= cnt_next;
        end
    end

endmodule
